// File: rtl/iter_alu.sv
// iter_alu: unsigned ALU with single-cycle logic/arith/compare/shift ops and
// iterative shift-add multiply and restoring divide (one bit per clock).
module iter_alu #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   operand_a,
   input  logic [DATA_WIDTH-1:0]   operand_b,
   input  logic [3:0]              alu_fun,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [2*DATA_WIDTH-1:0] alu_out,
   output logic                    out_valid,
   output logic                    err
);

   localparam int OUT_WIDTH = 2 * DATA_WIDTH;
   localparam int CNT_W     = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_NAND = 4'd6;
   localparam logic [3:0] OP_NOR  = 4'd7;
   localparam logic [3:0] OP_XOR  = 4'd8;
   localparam logic [3:0] OP_XNOR = 4'd9;
   localparam logic [3:0] OP_EQ   = 4'd10;
   localparam logic [3:0] OP_GT   = 4'd11;
   localparam logic [3:0] OP_LT   = 4'd12;
   localparam logic [3:0] OP_SHR  = 4'd13;
   localparam logic [3:0] OP_SHL  = 4'd14;
   localparam logic [3:0] OP_RSVD = 4'd15;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   is_div_q;
   logic [OUT_WIDTH-1:0]   alu_out_q;
   logic                   out_valid_q;
   logic                   err_q;

   // Iteration datapath registers (no reset: always loaded at accept)
   logic [OUT_WIDTH-1:0]   acc_q, acc_d;
   logic [OUT_WIDTH-1:0]   mcand_q, mcand_d;
   logic [DATA_WIDTH-1:0]  mplier_q, mplier_d;
   logic [DATA_WIDTH-1:0]  rem_q, rem_d;
   logic [DATA_WIDTH-1:0]  quo_q, quo_d;
   logic [DATA_WIDTH-1:0]  divisor_q;
   logic [DATA_WIDTH:0]    shifted;

   logic accept;
   logic div_by_zero;
   logic starts_iter;

   // Result of every opcode that completes in the accept cycle.
   function automatic logic [OUT_WIDTH-1:0] single_result(
      input logic [3:0]            fun,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b
   );
      logic [OUT_WIDTH-1:0]  r;
      logic [DATA_WIDTH:0]   wide;
      logic [DATA_WIDTH-1:0] narrow;
      r      = '0;
      wide   = '0;
      narrow = '0;
      case (fun)
         OP_ADD: begin
            wide = {1'b0, a} + {1'b0, b};
            r    = {{(DATA_WIDTH-1){1'b0}}, wide};
         end
         OP_SUB: begin
            // Bit DATA_WIDTH of the widened difference is the borrow.
            wide = {1'b0, a} - {1'b0, b};
            r    = {{(DATA_WIDTH-1){1'b0}}, wide};
         end
         OP_DIV: r = {a, {DATA_WIDTH{1'b1}}};
         OP_AND:  begin narrow = a & b;     r = {{DATA_WIDTH{1'b0}}, narrow}; end
         OP_OR:   begin narrow = a | b;     r = {{DATA_WIDTH{1'b0}}, narrow}; end
         OP_NAND: begin narrow = ~(a & b);  r = {{DATA_WIDTH{1'b0}}, narrow}; end
         OP_NOR:  begin narrow = ~(a | b);  r = {{DATA_WIDTH{1'b0}}, narrow}; end
         OP_XOR:  begin narrow = a ^ b;     r = {{DATA_WIDTH{1'b0}}, narrow}; end
         OP_XNOR: begin narrow = ~(a ^ b);  r = {{DATA_WIDTH{1'b0}}, narrow}; end
         OP_EQ:   r = {{(OUT_WIDTH-1){1'b0}}, (a == b)};
         OP_GT:   r = {{(OUT_WIDTH-1){1'b0}}, (a > b)};
         OP_LT:   r = {{(OUT_WIDTH-1){1'b0}}, (a < b)};
         OP_SHR:  begin narrow = a >> 1;    r = {{DATA_WIDTH{1'b0}}, narrow}; end
         OP_SHL: begin
            wide = {a, 1'b0};
            r    = {{(DATA_WIDTH-1){1'b0}}, wide};
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   assign in_ready    = (state_q == IDLE);
   assign accept      = in_ready && in_valid;
   assign div_by_zero = (alu_fun == OP_DIV) && (operand_b == '0);
   assign starts_iter = (alu_fun == OP_MUL) || ((alu_fun == OP_DIV) && !div_by_zero);

   assign alu_out   = alu_out_q;
   assign out_valid = out_valid_q;
   assign err       = err_q;

   // One multiply step (shift-add) and one restoring-divide step per edge.
   always_comb begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;

      // Bring the next dividend bit (MSB of quo_q) into the partial remainder.
      shifted = {rem_q, quo_q[DATA_WIDTH-1]};
      rem_d   = shifted[DATA_WIDTH-1:0];
      quo_d   = {quo_q[DATA_WIDTH-2:0], 1'b0};
      if (shifted >= {1'b0, divisor_q}) begin
         // Difference is below the divisor, so it fits in DATA_WIDTH bits.
         rem_d    = shifted[DATA_WIDTH-1:0] - divisor_q;
         quo_d[0] = 1'b1;
      end
   end

   // Load operands at accept, then advance the iteration while busy.
   always_ff @(posedge clk) begin
      if (accept) begin
         acc_q     <= '0;
         mcand_q   <= {{DATA_WIDTH{1'b0}}, operand_a};
         mplier_q  <= operand_b;
         rem_q     <= '0;
         quo_q     <= operand_a;
         divisor_q <= operand_b;
      end else if (state_q == BUSY) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
      end
   end

   // Control FSM with registered result, valid pulse and error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         is_div_q    <= 1'b0;
         alu_out_q   <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (starts_iter) begin
                     state_q  <= BUSY;
                     cnt_q    <= '0;
                     is_div_q <= (alu_fun == OP_DIV);
                  end else begin
                     alu_out_q   <= single_result(alu_fun, operand_a, operand_b);
                     out_valid_q <= 1'b1;
                     err_q       <= (alu_fun == OP_RSVD) || div_by_zero;
                  end
               end
            end
            BUSY: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_ITER) begin
                  state_q     <= IDLE;
                  alu_out_q   <= is_div_q ? {rem_d, quo_d} : acc_d;
                  out_valid_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter DATA_WIDTH, 8, operand width in bits; SHALL be supported for any value 2..32.
REQ-002 Derived OUT_WIDTH, 2*DATA_WIDTH, result width; SHALL NOT be overridable.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 operand_a  input  DATA_WIDTH  first operand, unsigned.
REQ-006 operand_b  input  DATA_WIDTH  second operand, unsigned.
REQ-007 alu_fun  input  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR, 9 XNOR, 10 CMP_EQ, 11 CMP_GT, 12 CMP_LT, 13 SHR, 14 SHL, 15 reserved.
REQ-008 in_valid  input  1  request present on operand_a/operand_b/alu_fun.
REQ-009 in_ready  output  1  block can accept a request this cycle.
REQ-010 alu_out  output  OUT_WIDTH  registered result.
REQ-011 out_valid  output  1  single-cycle pulse marking a new alu_out.
REQ-012 err  output  1  qualifies out_valid: division by zero or reserved opcode.

Function
REQ-013 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; operands and opcode SHALL be captured at accept, later input changes ignored.
REQ-014 States SHALL be IDLE and BUSY; in_ready=1 exactly when in IDLE (combinational from state).
REQ-015 Single-cycle ops (all except MUL/DIV, plus DIV with operand_b=0): accepted in cycle N -> alu_out/out_valid registered on that edge, visible cycle N+1; state stays IDLE.
REQ-016 ADD: alu_out = zero-extended A+B including carry in bit DATA_WIDTH.
REQ-017 SUB: alu_out[DATA_WIDTH-1:0] = (A-B) mod 2^DATA_WIDTH, bit DATA_WIDTH = borrow (A<B), upper bits 0.
REQ-018 Logic ops, SHR (A>>1), SHL (A<<1, shifted-out bit lands in bit DATA_WIDTH): zero-extended to OUT_WIDTH.
REQ-019 CMP_EQ/GT/LT: alu_out = 1 if A==B / A>B / A<B respectively, else 0.
REQ-020 MUL: IDLE->BUSY at accept; iterative shift-add, one partial product per edge, DATA_WIDTH iterations; full OUT_WIDTH product.
REQ-021 DIV (operand_b!=0): IDLE->BUSY at accept; restoring division, one quotient bit per edge, DATA_WIDTH iterations; alu_out = {remainder, quotient}, each DATA_WIDTH bits.
REQ-022 Iterative timing: accept in cycle N -> in_ready low cycles N+1..N+DATA_WIDTH; BUSY->IDLE on the last iteration edge; out_valid=1 and in_ready=1 in cycle N+DATA_WIDTH+1.
REQ-023 Iteration count SHALL use a counter of width clog2(DATA_WIDTH+1), cleared at accept.
REQ-024 DIV by zero: single-cycle; alu_out = {A, all-ones quotient}; err=1.
REQ-025 Reserved opcode 15: single-cycle; alu_out=0; err=1.
REQ-026 err SHALL be 0 whenever out_valid=0 and for all other results.
REQ-027 in_valid while BUSY SHALL be ignored (no queueing, no error); a new accept is legal in the same cycle out_valid is high.
REQ-028 alu_out SHALL hold its last value between out_valid pulses; out_valid SHALL never be high two consecutive cycles for one request.

Reset
REQ-029 rst=1 on an edge SHALL force state IDLE, counter 0, alu_out=0, out_valid=0, err=0; in_ready=1 from the following cycle.
REQ-030 rst during BUSY SHALL abandon the operation; no out_valid SHALL be produced for it.
REQ-031 rst SHALL take priority over a simultaneous accept; that request is dropped.

Verification (DATA_WIDTH=8)
REQ-032 ADD 0xFF,0x01 accepted cycle N -> cycle N+1 alu_out=0x0100, out_valid=1, err=0; cycle N+2 out_valid=0.
REQ-033 MUL 0xFF,0xFF accepted cycle N -> in_ready=0 cycles N+1..N+8; cycle N+9 alu_out=0xFE01, out_valid=1, in_ready=1.
REQ-034 DIV 200,7 -> after 9 cycles alu_out=0x041C (rem 4, quot 28); DIV 0x2A,0 -> next cycle alu_out=0x2AFF, err=1.
REQ-035 MUL accepted, rst pulsed at iteration 4 -> no out_valid ever for it, alu_out=0, in_ready=1 cycle after reset edge.
REQ-036 in_valid held high with SUB 0x05,0x09 throughout a DIV -> SUB accepted only in the DIV's out_valid cycle; next cycle alu_out=0x01FC, out_valid=1.
REQ-037 alu_fun=15 -> next cycle alu_out=0, out_valid=1, err=1.
